// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer.
// Selector encoding names the source of the value the PC loads next.
package next_pc_unit_pkg;

  localparam int DEFAULT_ADDR_W      = 64;
  localparam int DEFAULT_INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'd0,  // CurrentPC + INSTR_BYTES
    SEL_REL   = 3'd1,  // CurrentPC + (SignExtImm << IMM_SHIFT)
    SEL_REG   = 3'd2,  // RegTarget
    SEL_RAS   = 3'd3,  // top of the return-address stack
    SEL_REDIR = 3'd4   // RedirectPC (exception / boot)
  } next_sel_e;

endpackage

// File: rtl/next_pc_ras.sv
// Circular return-address stack. Pushing when full overwrites the oldest
// entry and the occupancy stays at DEPTH. A simultaneous push and pop
// replaces the top entry in place. Pops on an empty stack are ignored.
module next_pc_ras #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [CW-1:0]     count;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign top_data = mem[ptr];

  // Modulo-DEPTH neighbours of the top pointer (DEPTH need not be a power of two).
  always_comb begin
    ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    ptr_dec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - 1'b1;
  end

  // Stack storage, top pointer and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && do_pop) begin
      mem[ptr] <= push_data;
    end else if (push) begin
      mem[ptr_inc] <= push_data;
      ptr          <= ptr_inc;
      if (!full) begin
        count <= count + 1'b1;
      end
    end else if (do_pop) begin
      ptr   <= ptr_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Registered program-counter sequencer for the fetch stage.
// Selects the next PC every cycle (register-indirect, PC-relative,
// CBZ/CBNZ conditional, sequential), loads it on Advance, and lets
// Redirect override everything. Counts taken branches (saturating) and
// keeps a sticky flag for misaligned targets, whose low bits are cleared.
// Optional build macro NEXTPC_RAS_EN adds a return-address stack, the
// RetHint input, and BL pushes / hinted BR pops.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int                 ADDR_W       = DEFAULT_ADDR_W,
  parameter int                 INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter int                 IMM_SHIFT    = 2,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter int                 CNT_W        = 32,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Advance,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  input  logic              Branch,
  input  logic              BranchNZ,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  input  logic              BranchReg,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic [ADDR_W-1:0] SignExtImm,
  input  logic              Link,
`ifdef NEXTPC_RAS_EN
  input  logic              RetHint,
`endif
  output logic [ADDR_W-1:0] CurrentPC,
  output logic [ADDR_W-1:0] NextPC,
  output logic              Taken,
  output logic [CNT_W-1:0]  TakenCount,
  output logic              AlignFault
);

  // Bits below the instruction size must be zero in any PC value.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic [ADDR_W-1:0] raw_next;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              next_misaligned;
  logic              redirect_misaligned;
  logic              cond_taken;
  logic              ras_hit;
  logic [ADDR_W-1:0] ras_top;
  next_sel_e         next_sel;
  next_sel_e         pc_src;

  assign seq_pc     = CurrentPC + ADDR_W'(INSTR_BYTES);
  assign rel_pc     = CurrentPC + (SignExtImm << IMM_SHIFT);
  assign cond_taken = Branch & (ALUZero ^ BranchNZ);

`ifdef NEXTPC_RAS_EN
  logic ras_push;
  logic ras_pop;
  logic ras_full;
  logic ras_empty;
  logic unused_ras_full;

  assign ras_hit         = BranchReg & RetHint & ~ras_empty;
  assign ras_push        = ~Redirect & Advance & Link & Uncondbranch;
  assign ras_pop         = ~Redirect & Advance & ras_hit;
  assign unused_ras_full = ras_full;

  next_pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`else
  logic unused_link;

  assign ras_hit     = 1'b0;
  assign ras_top     = '0;
  assign unused_link = Link;
`endif

  // Next-PC source selection, first match wins.
  always_comb begin
    next_sel = SEL_SEQ;
    raw_next = seq_pc;
    if (BranchReg) begin
      if (ras_hit) begin
        next_sel = SEL_RAS;
        raw_next = ras_top;
      end else begin
        next_sel = SEL_REG;
        raw_next = RegTarget;
      end
    end else if (Uncondbranch || cond_taken) begin
      next_sel = SEL_REL;
      raw_next = rel_pc;
    end
  end

  // Alignment of the selected target and of the redirect target.
  always_comb begin
    NextPC              = raw_next & ~LOW_MASK;
    next_misaligned     = |(raw_next & LOW_MASK);
    redirect_aligned    = RedirectPC & ~LOW_MASK;
    redirect_misaligned = |(RedirectPC & LOW_MASK);
    Taken               = (next_sel != SEL_SEQ);
    pc_src              = Redirect ? SEL_REDIR : next_sel;
  end

  // PC register: redirect beats advance; no advance means stall.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CurrentPC <= RESET_VECTOR;
    end else if (Redirect || Advance) begin
      CurrentPC <= (pc_src == SEL_REDIR) ? redirect_aligned : NextPC;
    end
  end

  // Saturating taken-branch counter; redirects never count.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      TakenCount <= '0;
    end else if (!Redirect && Advance && Taken && (TakenCount != '1)) begin
      TakenCount <= TakenCount + 1'b1;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      AlignFault <= 1'b0;
    end else if (Redirect ? redirect_misaligned : (Advance && next_misaligned)) begin
      AlignFault <= 1'b1;
    end
  end

endmodule
